// File: rtl/cgra_inject_scheduler_if.sv
// Requester and router-local-port bundle for cgra_inject_scheduler.
//   master : scheduler side (drives req_ready, data_out, valid_out)
//   slave  : environment side (requesters and router local input)
// Signals:
//   req_valid/req_ready          per-requester handshake
//   req_dx/req_dy/req_payload    packed per-requester flit fields
//   data_out/valid_out/ready_in  router data_in_local/valid_in_local/ready_out_local
interface cgra_inject_scheduler_if #(
  parameter int unsigned NUM_REQ       = 4,
  parameter int unsigned COORD_WIDTH   = 4,
  parameter int unsigned PAYLOAD_WIDTH = 16,
  parameter int unsigned DATA_WIDTH    = 32
);
  logic [NUM_REQ-1:0]               req_valid;
  logic [NUM_REQ-1:0]               req_ready;
  logic [NUM_REQ*COORD_WIDTH-1:0]   req_dx;
  logic [NUM_REQ*COORD_WIDTH-1:0]   req_dy;
  logic [NUM_REQ*PAYLOAD_WIDTH-1:0] req_payload;
  logic [DATA_WIDTH-1:0]            data_out;
  logic                             valid_out;
  logic                             ready_in;

  modport master (
    input  req_valid, req_dx, req_dy, req_payload, ready_in,
    output req_ready, data_out, valid_out
  );

  modport slave (
    output req_valid, req_dx, req_dy, req_payload, ready_in,
    input  req_ready, data_out, valid_out
  );
endinterface

// File: rtl/cgra_inject_scheduler.sv
// Round-robin, burst-bounded scheduler sharing one router local input port
// among NUM_REQ on-tile requesters. Each accepted request is assembled into
// a flit {DX, DY, TAG, PAYLOAD} held in a single-entry output register.
// Ports:
//   clk, rst  clock, synchronous active-high reset
//   bus       cgra_inject_scheduler_if.master (requesters + router local port)
//   grant_id  current or last owner index
//   busy      high while a burst is in progress
// Optional feature: define CGRA_INJ_SRC_TAG_EN to place {X_COORD, Y_COORD}
// in the TAG field; otherwise TAG is 8'h00.
module cgra_inject_scheduler #(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned COORD_WIDTH   = 4,
  parameter int unsigned PAYLOAD_WIDTH = 16,
  parameter int unsigned NUM_REQ       = 4,
  parameter int unsigned MAX_BURST     = 4,
  parameter int unsigned X_COORD       = 0,
  parameter int unsigned Y_COORD       = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  cgra_inject_scheduler_if.master    bus,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       busy
);

  localparam int unsigned IW        = $clog2(NUM_REQ);
  localparam int unsigned CW        = $clog2(MAX_BURST + 1);
  localparam int unsigned TAG_WIDTH = DATA_WIDTH - 2 * COORD_WIDTH - PAYLOAD_WIDTH;
  localparam logic [TAG_WIDTH-1:0] SRC_TAG =
    TAG_WIDTH'({4'(X_COORD), 4'(Y_COORD)});
`ifdef CGRA_INJ_SRC_TAG_EN
  localparam bit TAG_EN = 1'b1;
`else
  localparam bit TAG_EN = 1'b0;
`endif
  localparam logic [TAG_WIDTH-1:0] TAG = TAG_EN ? SRC_TAG : '0;

  typedef enum logic {
    S_IDLE,
    S_BURST
  } state_t;

  state_t               state, state_nxt;
  logic [IW-1:0]        rr_ptr, rr_nxt;
  logic [IW-1:0]        owner, owner_nxt;
  logic [IW-1:0]        grant_nxt;
  logic [CW-1:0]        cnt, cnt_nxt;
  logic [CW-1:0]        cnt_inc_c;
  logic [NUM_REQ-1:0]   ready_c;
  logic                 xfer_c;
  logic [IW-1:0]        sel_c;
  logic [IW-1:0]        winner_c;
  logic                 slot_free_c;
  logic [DATA_WIDTH-1:0] flit_c;

  logic [COORD_WIDTH-1:0]   dx_arr  [NUM_REQ];
  logic [COORD_WIDTH-1:0]   dy_arr  [NUM_REQ];
  logic [PAYLOAD_WIDTH-1:0] pay_arr [NUM_REQ];

  // Unpack per-requester fields so the transfer mux is a plain array select
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign dx_arr[i]  = bus.req_dx[i*COORD_WIDTH +: COORD_WIDTH];
    assign dy_arr[i]  = bus.req_dy[i*COORD_WIDTH +: COORD_WIDTH];
    assign pay_arr[i] = bus.req_payload[i*PAYLOAD_WIDTH +: PAYLOAD_WIDTH];
  end

  // First valid index at or above ptr, wrapping modulo NUM_REQ
  function automatic logic [IW-1:0] rr_pick(input logic [NUM_REQ-1:0] v,
                                            input logic [IW-1:0] ptr);
    logic [IW-1:0] pick;
    logic          hit;
    pick = ptr;
    hit  = 1'b0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      int unsigned idx;
      idx = (32'(ptr) + k) % NUM_REQ;
      if (!hit && v[IW'(idx)]) begin
        hit  = 1'b1;
        pick = IW'(idx);
      end
    end
    return pick;
  endfunction

  // Successor index modulo NUM_REQ (NUM_REQ need not be a power of two)
  function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] i);
    return (i == IW'(NUM_REQ - 1)) ? '0 : i + IW'(1);
  endfunction

  assign slot_free_c = !bus.valid_out || bus.ready_in;
  assign winner_c    = rr_pick(bus.req_valid, rr_ptr);
  assign cnt_inc_c   = cnt + CW'(1);
  assign flit_c      = {dx_arr[sel_c], dy_arr[sel_c], TAG, pay_arr[sel_c]};

  // req_ready is combinational on req_valid/ready_in and forced low in reset
  assign bus.req_ready = rst ? '0 : ready_c;

  // State register and output flit register
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      rr_ptr        <= '0;
      owner         <= '0;
      cnt           <= '0;
      grant_id      <= '0;
      busy          <= 1'b0;
      bus.valid_out <= 1'b0;
      bus.data_out  <= '0;
    end else begin
      state    <= state_nxt;
      rr_ptr   <= rr_nxt;
      owner    <= owner_nxt;
      cnt      <= cnt_nxt;
      grant_id <= grant_nxt;
      busy     <= (state_nxt == S_BURST);
      if (xfer_c) begin
        bus.data_out  <= flit_c;
        bus.valid_out <= 1'b1;
      end else if (slot_free_c) begin
        bus.valid_out <= 1'b0;
      end
    end
  end

  // Arbitration, burst accounting and next-state logic
  always_comb begin
    state_nxt = state;
    rr_nxt    = rr_ptr;
    owner_nxt = owner;
    grant_nxt = grant_id;
    cnt_nxt   = cnt;
    ready_c   = '0;
    xfer_c    = 1'b0;
    sel_c     = owner;

    unique case (state)
      S_IDLE: begin
        if (slot_free_c && (|bus.req_valid)) begin
          sel_c             = winner_c;
          ready_c[winner_c] = 1'b1;
          xfer_c            = 1'b1;
          owner_nxt         = winner_c;
          grant_nxt         = winner_c;
          cnt_nxt           = CW'(1);
          if (MAX_BURST == 1) begin
            rr_nxt = next_idx(winner_c);
          end else begin
            state_nxt = S_BURST;
          end
        end
      end
      S_BURST: begin
        // Without a free slot the burst is frozen: neither counted nor ended
        if (slot_free_c) begin
          if (bus.req_valid[owner]) begin
            ready_c[owner] = 1'b1;
            xfer_c         = 1'b1;
            cnt_nxt        = cnt_inc_c;
            if (cnt_inc_c == CW'(MAX_BURST)) begin
              state_nxt = S_IDLE;
              rr_nxt    = next_idx(owner);
            end
          end else begin
            // Owner released: costs one idle arbitration cycle
            state_nxt = S_IDLE;
            rr_nxt    = next_idx(owner);
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: doc/cgra_inject_scheduler.md
# cgra_inject_scheduler

- Round-robin scheduler that shares one router's local input port among `NUM_REQ` on-tile requesters (PE result port, config echo, DMA, debug).
- Assembles each request into an in-band routed flit: `[31:28 DX][27:24 DY][23:16 TAG][15:0 PAYLOAD]`.
- Holds the flit in a single-entry output register that drives the router local input (`data_in_local`/`valid_in_local`/`ready_out_local`).
- Grants the local port in bounded bursts so no requester can starve the others.

## Interface

Parameters:
- `DATA_WIDTH`, 32: flit width; must be 32.
- `COORD_WIDTH`, 4: width of DX/DY fields.
- `PAYLOAD_WIDTH`, 16: payload width.
- `NUM_REQ`, 4: number of requesters; 2..8.
- `MAX_BURST`, 4: maximum consecutive flits per grant; 1..15.
- `X_COORD`, 0: this tile's X coordinate, used for the source tag.
- `Y_COORD`, 0: this tile's Y coordinate, used for the source tag.

Ports:
- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: reset; synchronous, active-high.
- `req_valid` in `NUM_REQ`: per-requester flit valid.
- `req_ready` out `NUM_REQ`: per-requester accept; at most one bit high in any cycle.
- `req_dx` in `NUM_REQ*COORD_WIDTH`: destination X, requester i at slice `[i*COORD_WIDTH +: COORD_WIDTH]`.
- `req_dy` in `NUM_REQ*COORD_WIDTH`: destination Y, packed the same way as `req_dx`.
- `req_payload` in `NUM_REQ*PAYLOAD_WIDTH`: payload, packed the same way.
- `data_out` out `DATA_WIDTH`: flit to router `data_in_local`.
- `valid_out` out 1: to router `valid_in_local`.
- `ready_in` in 1: from router `ready_out_local`.
- `grant_id` out `$clog2(NUM_REQ)`: current or last owner index.
- `busy` out 1: high while in BURST state.

## Operation

- **Slot free:** `slot_free = !valid_out || ready_in`. This is the same skid rule the router buffers use.
- **Transfer:** a transfer from requester i occurs in a cycle when `req_valid[i] && req_ready[i]`.
- **On transfer:** the output register loads `{dx_i, dy_i, TAG, payload_i}` and `valid_out` is set to 1.
- **Slot free with no transfer:** `valid_out` is cleared to 0.
- **Slot not free:** `data_out` and `valid_out` hold.
- **State IDLE:**
  - When `slot_free` and any `req_valid` is high, the winner is the first valid index searching upward from `rr_ptr` with wrap.
  - Winner gets `req_ready` in the same cycle; the flit transfers.
  - `owner` = winner, `grant_id` = winner, `cnt` = 1.
  - Next state is BURST, except go to IDLE with `rr_ptr` = winner+1 (mod `NUM_REQ`) when `MAX_BURST` == 1.
- **State BURST:**
  - `req_ready[owner] = slot_free && req_valid[owner]`; all other `req_ready` bits are 0.
  - Each transfer increments `cnt`.
  - When the `MAX_BURST`-th transfer completes, go to IDLE and set `rr_ptr` = `owner`+1 (mod `NUM_REQ`).
  - When `slot_free && !req_valid[owner]` (owner released), go to IDLE and set `rr_ptr` = `owner`+1, with no transfer that cycle.
  - When `!slot_free`, hold all state; the burst is neither ended nor counted.
- **Dependency:** `req_ready` depends combinationally on `req_valid` and `ready_in`. Requesters must not derive `req_valid` from `req_ready`.
- **Flit fields:** DX/DY are copied unmodified. A destination equal to (`X_COORD`, `Y_COORD`) is legal and is routed back to the local port by the router.

## Timing

- **Latency:** a flit accepted in cycle N appears on `data_out`/`valid_out` in cycle N+1.
- **Throughput:** one flit per cycle sustained within a burst while `ready_in`=1.
- **Arbitration bubble:** exactly 1 cycle with no transfer after an owner release. There is no bubble after a `MAX_BURST` completion; IDLE arbitrates in the next cycle.
- **Reset values:** `valid_out`=0, `data_out`=0, `req_ready`=0 (forced while `rst`), `grant_id`=0, `busy`=0, state=IDLE, `rr_ptr`=0, `cnt`=0.
- **Reset mid-burst:** the pending output flit is discarded. The first post-reset grant searches from index 0.
- **Backpressure:** while `valid_out`=1 and `ready_in`=0, `data_out` is stable and no `req_ready` is asserted.

## Configuration

- **Macro:** `CGRA_INJ_SRC_TAG_EN`.
- **Defined:** TAG[23:16] = `{X_COORD[3:0], Y_COORD[3:0]}`, the source-tile tag used by the destination for reply routing.
- **Not defined:** TAG[23:16] = 8'h00, matching the router's reserved-field convention.
- The macro does not affect arbitration or timing.

## Test plan

- **Single requester burst:** `NUM_REQ`=4, `MAX_BURST`=4, req0 valid continuously with payloads 0x0001..0x0006, dx=2, dy=1, `ready_in`=1. Required: flits 0x2100_0001..0x2100_0004 on consecutive cycles; IDLE re-grants req0 (the only requester) immediately; no gap.
- **Fairness:** req1 and req3 both always valid, `MAX_BURST`=2. Required grant sequence 1,1,3,3,1,1,…; `grant_id` matches; at most one `req_ready` high each cycle.
- **Backpressure:** `ready_in`=0 for 3 cycles after the first flit 0x1200_ABCD. Required: `data_out` holds 0x1200_ABCD, all `req_ready`=0, `busy` holds; the next flit appears 1 cycle after `ready_in` returns to 1.
- **Owner release:** req2 deasserts after 1 of 4 burst flits while req0 is valid. Required: one cycle with no transfer, then req0 granted (`rr_ptr`=3 wraps to 0).
- **Reset mid-burst:** `rst` high for 1 cycle with `valid_out`=1. Required: next cycle `valid_out`=0, `data_out`=0, `busy`=0; the first grant afterwards goes to the lowest valid index.
- **Source tag:** `X_COORD`=3, `Y_COORD`=5, dx=0, dy=0, payload 0x00FF. Required: with `CGRA_INJ_SRC_TAG_EN`, flit 0x0035_00FF; without it, 0x0000_00FF.
